fifo_sync_reader: RTL and testbench



---
 rtl/fifo_sync_reader.sv | 67 ++++++
 tb/tb_fifo_sync_reader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_reader.sv
// fifo_sync_reader: pops words from a fifo_sync read port, absorbs the
// FIFO's one-cycle read latency, and presents them on a valid/ready stream
// through a 2-entry buffer (head/tail). One word per clock when unblocked.
module fifo_sync_reader #(
  parameter int MEMORY_WIDTH = 4,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    empty,
  input  logic [MEMORY_WIDTH-1:0] rdata,
  output logic                    r_en,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [MEMORY_WIDTH-1:0] m_data,
  output logic [COUNT_WIDTH-1:0]  beat_count
);

  logic [1:0]              occ;       // buffered words, 0..2
  logic                    inflight;  // pop issued last cycle, word on rdata now
  logic [MEMORY_WIDTH-1:0] head;
  logic [MEMORY_WIDTH-1:0] tail;

  logic       take;
  logic [1:0] occ_left;  // occupancy after this cycle's take
  logic [2:0] pending;   // occupancy after take plus the arriving word

  assign m_valid = (occ != 2'd0);
  assign m_data  = head;

  // Pop only if the word arriving next cycle is guaranteed a buffer slot;
  // counting the in-flight word keeps the 2-entry buffer from overflowing.
  always_comb begin
    take     = m_valid & m_ready;
    occ_left = occ - {1'b0, take};
    pending  = {1'b0, occ_left} + {2'b0, inflight};
    r_en     = ~rst & en & ~empty & (pending < 3'd2);
  end

  // Buffer shift on take, capture of the in-flight word, and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ        <= 2'd0;
      inflight   <= 1'b0;
      head       <= '0;
      tail       <= '0;
      beat_count <= '0;
    end else begin
      if (take && occ == 2'd2)
        head <= tail;
      // Arriving word lands at the head if the buffer drains this cycle,
      // otherwise behind the (possibly just promoted) head.
      if (inflight) begin
        if (occ_left == 2'd0)
          head <= rdata;
        else
          tail <= rdata;
      end
      occ      <= pending[1:0];
      inflight <= r_en;
      if (take)
        beat_count <= beat_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_sync_reader.sv
// Directed bench for fifo_sync_reader with a behavioural 4x4 fifo_sync model.
// Cycle vectors are table-driven; the power-up reset is a hand sequence.
module tb_fifo_sync_reader;

  logic       clk = 1'b0;
  logic       rst, en, m_ready;
  logic       empty, r_en, m_valid;
  logic [3:0] rdata, m_data;
  logic [1:0] beat_count;

  // fifo_sync model controls
  logic       push, clr;
  logic [3:0] push_data;
  logic [3:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;

  int tests = 0;
  int fails = 0;
  int row   = -1;

  always #5 clk = ~clk;

  fifo_sync_reader #(.MEMORY_WIDTH(4), .COUNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .en(en), .empty(empty), .rdata(rdata),
    .r_en(r_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .beat_count(beat_count)
  );

  // Behavioural fifo_sync: registered read data, one-cycle latency.
  assign empty = (cnt == 3'd0);
  always @(posedge clk) begin
    if (clr) begin
      wp <= 2'd0; rp <= 2'd0; cnt <= 3'd0; rdata <= 4'd0;
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp      <= wp + 2'd1;
      end
      if (r_en && !empty) begin
        rdata <= mem[rp];
        rp    <= rp + 2'd1;
      end
      cnt <= cnt + {2'b0, push} - {2'b0, (r_en && !empty)};
    end
  end

  typedef struct {
    logic       rst, en, rdy, push;
    logic [3:0] pd;
    logic       er, ev;
    logic [3:0] ed;
    logic [1:0] eb;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic r, logic e, logic y, logic p, logic [3:0] d,
                              logic er, logic ev, logic [3:0] ed, logic [1:0] eb);
    vec_t v;
    v.rst = r; v.en = e; v.rdy = y; v.push = p; v.pd = d;
    v.er = er; v.ev = ev; v.ed = ed; v.eb = eb;
    vq.push_back(v);
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic chk_outs(logic er, logic ev, logic [3:0] ed, logic [1:0] eb);
    chk("r_en", int'(r_en), int'(er));
    chk("m_valid", int'(m_valid), int'(ev));
    chk("m_data", int'(m_data), int'(ed));
    chk("beat_count", int'(beat_count), int'(eb));
    chk("no_pop_when_empty", int'(r_en && empty), 0);
    chk("occ_le_2", int'(dut.occ <= 2'd2), 1);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b1; en = 1'b0; m_ready = 1'b0; push = 1'b0; push_data = 4'd0;

    //        rst en rdy push pd   r_en vld data beat
    // basic drain 1,2,3
    add(0, 0, 1, 1, 4'd1,  0, 0, 4'd0, 2'd0);
    add(0, 0, 1, 1, 4'd2,  0, 0, 4'd0, 2'd0);
    add(0, 0, 1, 1, 4'd3,  0, 0, 4'd0, 2'd0);
    add(0, 1, 1, 0, 4'd0,  1, 0, 4'd0, 2'd0);
    add(0, 1, 1, 0, 4'd0,  1, 0, 4'd0, 2'd0);
    add(0, 1, 1, 0, 4'd0,  1, 1, 4'd1, 2'd0);
    add(0, 1, 1, 0, 4'd0,  0, 1, 4'd2, 2'd1);
    add(0, 1, 1, 0, 4'd0,  0, 1, 4'd3, 2'd2);
    add(0, 1, 1, 0, 4'd0,  0, 0, 4'd3, 2'd3);
    // backpressure: fill 4..7 with en=0 (full FIFO, no pops), then stall
    add(0, 0, 0, 1, 4'd4,  0, 0, 4'd3, 2'd3);
    add(0, 0, 0, 1, 4'd5,  0, 0, 4'd3, 2'd3);
    add(0, 0, 0, 1, 4'd6,  0, 0, 4'd3, 2'd3);
    add(0, 0, 0, 1, 4'd7,  0, 0, 4'd3, 2'd3);
    add(0, 0, 0, 0, 4'd0,  0, 0, 4'd3, 2'd3);
    add(0, 1, 0, 0, 4'd0,  1, 0, 4'd3, 2'd3);
    add(0, 1, 0, 0, 4'd0,  1, 0, 4'd3, 2'd3);
    add(0, 1, 0, 0, 4'd0,  0, 1, 4'd4, 2'd3);
    add(0, 1, 0, 0, 4'd0,  0, 1, 4'd4, 2'd3);
    add(0, 1, 1, 0, 4'd0,  1, 1, 4'd4, 2'd3);
    add(0, 1, 1, 0, 4'd0,  1, 1, 4'd5, 2'd0);
    add(0, 1, 1, 0, 4'd0,  0, 1, 4'd6, 2'd1);
    add(0, 1, 1, 0, 4'd0,  0, 1, 4'd7, 2'd2);
    add(0, 1, 1, 0, 4'd0,  0, 0, 4'd7, 2'd3);
    // enable gating: one pop, then en dropped; in-flight word still delivered
    add(0, 0, 1, 1, 4'd8,  0, 0, 4'd7, 2'd3);
    add(0, 0, 1, 1, 4'd9,  0, 0, 4'd7, 2'd3);
    add(0, 0, 1, 1, 4'd10, 0, 0, 4'd7, 2'd3);
    add(0, 1, 1, 0, 4'd0,  1, 0, 4'd7, 2'd3);
    add(0, 0, 1, 0, 4'd0,  0, 0, 4'd7, 2'd3);
    add(0, 0, 1, 0, 4'd0,  0, 1, 4'd8, 2'd3);
    add(0, 0, 1, 0, 4'd0,  0, 0, 4'd8, 2'd0);
    // reset mid-stream: 10 buffered and 11 in flight are discarded
    add(0, 0, 1, 1, 4'd11, 0, 0, 4'd8, 2'd0);
    add(0, 0, 1, 1, 4'd12, 0, 0, 4'd8, 2'd0);
    add(0, 1, 1, 0, 4'd0,  1, 0, 4'd8, 2'd0);
    add(0, 1, 1, 0, 4'd0,  1, 0, 4'd8, 2'd0);
    add(0, 1, 1, 0, 4'd0,  1, 1, 4'd9, 2'd0);
    add(1, 1, 0, 0, 4'd0,  0, 1, 4'd10, 2'd1);
    add(0, 1, 1, 0, 4'd0,  1, 0, 4'd0, 2'd0);
    add(0, 1, 1, 0, 4'd0,  0, 0, 4'd0, 2'd0);
    add(0, 1, 1, 0, 4'd0,  0, 1, 4'd12, 2'd0);
    add(0, 1, 1, 0, 4'd0,  0, 0, 4'd12, 2'd1);

    // Power-up reset; a word enters the FIFO so empty drops while rst is held.
    @(posedge clk); #1;
    clr = 1'b0; push = 1'b1; push_data = 4'd15; m_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk_outs(0, 0, 4'd0, 2'd0);
    @(posedge clk); #1;
    push = 1'b0; en = 1'b1; m_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("empty_low_in_reset", int'(empty), 0);
    chk_outs(0, 0, 4'd0, 2'd0);
    @(posedge clk); #1;
    clr = 1'b1; en = 1'b0;
    @(negedge clk);
    chk_outs(0, 0, 4'd0, 2'd0);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      row = i;
      clr = 1'b0;
      rst = vq[i].rst; en = vq[i].en; m_ready = vq[i].rdy;
      push = vq[i].push; push_data = vq[i].pd;
      @(negedge clk);
      chk_outs(vq[i].er, vq[i].ev, vq[i].ed, vq[i].eb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
